inv_round_key_seq: RTL and testbench

//  Sequential AES-128 decryption key scheduler: accepts a cipher key, runs the forward schedule
//  to round key 10 in 10 cycles, then streams round keys 10,9,...,0 by inverse key expansion.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/key_step_inv.sv | 42 ++++
 rtl/s_box.sv | 28 ++
 rtl/inv_round_key_seq.sv | 125 ++++++++++++
 tb/tb_inv_round_key_seq.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, round constants and
// the scheduler state encoding.
package aes_pkg;

    localparam int AES_ROUNDS = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_STREAM
    } ks_state_e;

    // Round constant for the step that produces round key r (r = 1..10).
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/key_step_inv.sv
// One combinational AES-128 key-schedule step: inverse (K_r -> K_r-1) by
// default, forward (K_r-1 -> K_r) when fwd_i is set. One shared S-box bank.
module key_step_inv (
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    input  logic         fwd_i,
    output logic [127:0] key_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t1, t2, t3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] sb_in, rot, sub, g;

    assign {w0, w1, w2, w3} = key_i;

    // Inverse step recovers the previous w1..w3 first; w3 of the previous
    // key is what feeds RotWord/SubWord in that direction.
    assign t3 = w3 ^ w2;
    assign t2 = w2 ^ w1;
    assign t1 = w1 ^ w0;

    assign sb_in = fwd_i ? w3 : t3;
    assign rot   = {sb_in[23:0], sb_in[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        s_box u_s_box (
            .a_i(rot[8*i +: 8]),
            .y_o(sub[8*i +: 8])
        );
    end

    assign g  = sub ^ {rcon_i, 24'h000000};

    assign f0 = w0 ^ g;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign key_o = fwd_i ? {f0, f1, f2, f3} : {f0, t1, t2, t3};

endmodule

// File: rtl/s_box.sv
// AES forward S-box, purely combinational table lookup.
module s_box (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y_o = SBOX[a_i];

endmodule

// File: rtl/inv_round_key_seq.sv
// Sequential AES-128 decryption key scheduler: expands to round key 10, then
// streams round keys 10..0. Optional replay of the stream via INV_KEY_REPLAY_EN.
module inv_round_key_seq
    import aes_pkg::*;
#(
    parameter int ROUNDS = AES_ROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
`ifdef INV_KEY_REPLAY_EN
    input  logic         replay,
`endif
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    ks_state_e    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] step_key;
    logic         fwd;
    logic         expand_done;

    // round_q is the expansion counter in EXPAND and the round index in STREAM,
    // so the same register selects rcon for both directions.
    assign fwd         = (state_q == ST_EXPAND);
    assign expand_done = (state_q == ST_EXPAND) && (round_q == LAST_ROUND);

    key_step_inv u_step (
        .key_i (key_q),
        .rcon_i(rcon(round_q)),
        .fwd_i (fwd),
        .key_o (step_key)
    );

`ifdef INV_KEY_REPLAY_EN
    logic [127:0] last_key_q;
    logic         has_key_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            has_key_q <= 1'b0;
        end else if (expand_done) begin
            has_key_q <= 1'b1;
        end
    end

    // NOTE: last_key_q is pure data qualified by has_key_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (expand_done) begin
            last_key_q <= step_key;
        end
    end
`endif

    // NOTE: every signal gets its default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    key_d   = key_in;
                    round_d = 4'd1;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                key_d = step_key;
                if (round_q == LAST_ROUND) begin
                    state_d = ST_STREAM;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            ST_STREAM: begin
                if (rk_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        key_d   = step_key;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef INV_KEY_REPLAY_EN
        if (replay && has_key_q && (state_q != ST_EXPAND)) begin
            key_d   = last_key_q;
            round_d = LAST_ROUND;
            state_d = ST_STREAM;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    assign key_ready = (state_q == ST_IDLE) && !rst;
    assign rk_valid  = (state_q == ST_STREAM);
    assign busy      = (state_q != ST_IDLE);
    assign rk_out    = key_q;
    assign rk_round  = round_q;

endmodule

// File: tb/tb_inv_round_key_seq.sv
// Self-checking bench for inv_round_key_seq: forward-expansion reference model
// checked every cycle, plus directed FIPS-197 vectors. Honours INV_KEY_REPLAY_EN.
module tb_inv_round_key_seq;

    localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K1_9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K1_1  = 128'ha0fafe1788542cb123a339392a6c7605;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
`ifdef INV_KEY_REPLAY_EN
    logic         replay;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    inv_round_key_seq dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_in   (key_in),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
`ifdef INV_KEY_REPLAY_EN
        .replay   (replay),
`endif
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: GF(2^8) S-box and forward expansion
    logic [7:0]   sbox_t [256];
    logic [127:0] calc_rk [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic compute_rks(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) calc_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- per-cycle model and compare process
    logic [127:0] m_rk [11];
    logic [127:0] m_out   = '0;
    logic [127:0] m_last  = '0;
    logic [3:0]   m_round = '0;
    logic         m_valid = 1'b0;
    logic         m_known = 1'b0;
    logic         m_have  = 1'b0;
    int           m_wait  = 0;

    always @(negedge clk) begin
        logic m_idle;
        m_idle = !m_valid && (m_wait == 0);
        check("cmp_rk_valid", rk_valid, m_valid);
        check("cmp_busy", busy, !m_idle);
        check("cmp_key_ready", key_ready, m_idle && !rst);
        if (m_known) begin
            check("cmp_rk_out", rk_out, m_out);
            check("cmp_rk_round", rk_round, m_round);
        end
        // advance the model to what must hold after the coming rising edge
        if (rst) begin
            m_valid = 1'b0; m_wait = 0; m_out = '0; m_round = '0;
            m_known = 1'b1; m_have = 1'b0;
        end else if (m_wait != 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1; m_round = 4'd10; m_out = m_rk[10];
                m_last  = m_rk[10]; m_have = 1'b1; m_known = 1'b1;
            end
        end
`ifdef INV_KEY_REPLAY_EN
        else if (replay && m_have) begin
            m_valid = 1'b1; m_round = 4'd10; m_out = m_last;
        end
`endif
        else if (m_valid) begin
            if (rk_ready) begin
                if (m_round == 4'd0) begin
                    m_valid = 1'b0;
                end else begin
                    m_round = m_round - 4'd1;
                    m_out   = m_rk[m_round];
                end
            end
        end else if (key_valid) begin
            compute_rks(key_in);
            m_rk    = calc_rk;
            m_wait  = 10;
            m_known = 1'b0;
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k, output int lat);
        key_in = k; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        lat = 1;
        while (!rk_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("stream_started", rk_valid, 1'b1);
    endtask

    task automatic drain(input bit random_ready);
        int guard;
        guard = 0;
        while (rk_valid && guard < 300) begin
            rk_ready = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            guard++;
        end
        rk_ready = 1'b0;
        check("drain_end", rk_valid, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n_hs, guard;
        rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_ready = 1'b0;
`ifdef INV_KEY_REPLAY_EN
        replay = 1'b0;
`endif
        build_sbox();
        compute_rks(K1);
        check("pin_model_rk10", calc_rk[10], K1_10);
        check("pin_model_rk9", calc_rk[9], K1_9);
        check("pin_model_rk1", calc_rk[1], K1_1);
        check("pin_model_rk0", calc_rk[0], K1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rk_valid", rk_valid, 1'b0);
        check("reset_key_ready", key_ready, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_rk_out", rk_out, '0);
        check("reset_rk_round", rk_round, 4'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_key_ready", key_ready, 1'b1);

        // 1/2: FIPS-197 key, full throughput
        load_key(K1, lat);
        check("t1_latency", lat, 11);
        check("t1_round10", rk_round, 4'd10);
        check("t1_rk10", rk_out, K1_10);
        rk_ready = 1'b1;
        tick();
        check("t1_round9", rk_round, 4'd9);
        check("t1_rk9", rk_out, K1_9);
        repeat (8) tick();
        check("t2_round1", rk_round, 4'd1);
        check("t2_rk1", rk_out, K1_1);
        tick();
        check("t2_round0", rk_round, 4'd0);
        check("t2_rk0", rk_out, K1);
        tick();
        rk_ready = 1'b0;
        check("t2_end_valid", rk_valid, 1'b0);
        check("t2_end_key_ready", key_ready, 1'b1);
        check("t2_hold_rk_out", rk_out, K1);

        // 3: random backpressure, exactly 11 accepted keys
        load_key(K1, lat);
        n_hs = 0; guard = 0;
        while (rk_valid && guard < 300) begin
            rk_ready = 1'($urandom_range(0, 1));
            if (rk_ready) n_hs++;
            tick();
            guard++;
        end
        rk_ready = 1'b0;
        check("t3_keys_accepted", n_hs, 11);

        // 4: key_valid ignored while busy; reset mid-EXPAND and mid-STREAM
        key_in = K1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (3) tick();
        key_in = ~K1; key_valid = 1'b1;
        repeat (2) tick();
        key_valid = 1'b0;
        guard = 0;
        while (!rk_valid && guard < 40) begin
            tick();
            guard++;
        end
        check("t4_rk10_after_pulse", rk_out, K1_10);
        rk_ready = 1'b1;
        key_in = 128'h0123456789abcdef0123456789abcdef; key_valid = 1'b1;
        repeat (3) tick();
        key_valid = 1'b0;
        check("t4_round7_after_pulse", rk_round, 4'd7);
        drain(1'b1);

        load_key(K1, lat);
        drain(1'b0);
        key_in = K1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("t4_rst_exp_valid", rk_valid, 1'b0);
        check("t4_rst_exp_busy", busy, 1'b0);
        check("t4_rst_exp_rk_out", rk_out, '0);
        rst = 1'b0;
        tick();

        load_key(K1, lat);
        rk_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("t4_rst_str_valid", rk_valid, 1'b0);
        check("t4_rst_str_rk_out", rk_out, '0);
        check("t4_rst_str_round", rk_round, 4'd0);
        rst = 1'b0; rk_ready = 1'b0;
        tick();
        check("t4_rst_key_ready", key_ready, 1'b1);

`ifdef INV_KEY_REPLAY_EN
        // 5: replay mid-stream with a same-cycle handshake, then after stream end
        load_key(K1, lat);
        rk_ready = 1'b1;
        repeat (6) tick();
        check("t5_round4", rk_round, 4'd4);
        replay = 1'b1;
        tick();
        replay = 1'b0;
        check("t5_replay_round", rk_round, 4'd10);
        check("t5_replay_rk", rk_out, K1_10);
        repeat (11) tick();
        rk_ready = 1'b0;
        check("t5_stream_ended", rk_valid, 1'b0);
        replay = 1'b1;
        tick();
        replay = 1'b0;
        check("t5_idle_replay_round", rk_round, 4'd10);
        check("t5_idle_replay_rk", rk_out, K1_10);
        drain(1'b0);
`endif

        // 6: random keys against the model
        for (int i = 0; i < 1000; i++) begin
            load_key({$urandom(), $urandom(), $urandom(), $urandom()}, lat);
            check("t6_latency", lat, 11);
            drain(1'b1);
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
